// File: rtl/afifo_pkg.sv
// Shared definitions for the async FIFO read-side controller.
// Contents: read-controller state encoding and the default parameter values.
package afifo_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 8;
    localparam int unsigned BUF_DEPTH_DEF  = 4;
    localparam int unsigned CNT_W_DEF      = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        FLUSH  = 2'd3
    } rd_state_e;

endpackage

// File: rtl/afifo_rd_buf.sv
// First-word-fall-through output buffer for the read controller.
// Ports:
//   rd_clk, clear_n  - clock and asynchronous active-low reset
//   push_i           - write push_data_i into the tail (caller guarantees space)
//   pop_i            - consume the head entry (ignored while empty)
//   head_o           - current head entry
//   occ_o            - number of stored entries
module afifo_rd_buf
    import afifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned BUF_DEPTH  = BUF_DEPTH_DEF,
    localparam int unsigned PTR_W     = $clog2(BUF_DEPTH),
    localparam int unsigned OCC_W     = PTR_W + 1
) (
    input  logic                  rd_clk,
    input  logic                  clear_n,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] head_o,
    output logic [OCC_W-1:0]      occ_o
);

    logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [OCC_W-1:0]      occ_q;
    logic                  pop;

    assign pop = pop_i && (occ_q != '0);

    // Storage, pointers and occupancy; push+pop together leaves occupancy unchanged.
    always_ff @(posedge rd_clk or negedge clear_n) begin
        if (!clear_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push_i, pop})
                2'b10:   occ_q <= occ_q + OCC_W'(1);
                2'b01:   occ_q <= occ_q - OCC_W'(1);
                default: occ_q <= occ_q;
            endcase
        end
    end

    assign head_o = mem_q[rd_ptr_q];
    assign occ_o  = occ_q;

    // The controller's credit check must make an overflowing push impossible.
    a_no_overflow: assert property (@(posedge rd_clk) disable iff (!clear_n)
        !(push_i && !pop && (occ_q == OCC_W'(BUF_DEPTH))));

endmodule

// File: rtl/afifo_rd_ctrl.sv
// Read-side controller for async_fifo in the rd_clk domain.
// Issues rd_en under a credit/throttle rule, captures dout on rd_ack into an
// FWFT buffer and presents it as a valid/ready stream. Stream mode runs while
// enable is high; drain mode reads exactly drain_len words.
// Ports:
//   rd_clk, clear_n                - clock, asynchronous active-low reset
//   enable, drain_start, drain_len - mode requests
//   rd_en, empty, almost_empty,
//   rd_ack, rd_err, dout           - FIFO read interface
//   m_data, m_valid, m_ready       - output stream
//   drain_busy, drain_done         - drain status
//   words_rd, err_rd, err_ack      - accepted-word count and sticky error flags
module afifo_rd_ctrl
    import afifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned BUF_DEPTH  = BUF_DEPTH_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF
) (
    input  logic                  rd_clk,
    input  logic                  clear_n,
    input  logic                  enable,
    input  logic                  drain_start,
    input  logic [CNT_W-1:0]      drain_len,
    output logic                  rd_en,
    input  logic                  empty,
    input  logic                  almost_empty,
    input  logic                  rd_ack,
    input  logic                  rd_err,
    input  logic [DATA_WIDTH-1:0] dout,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  drain_busy,
    output logic                  drain_done,
    output logic [CNT_W-1:0]      words_rd,
    output logic                  err_rd,
    output logic                  err_ack
);

    localparam int unsigned OCC_W = $clog2(BUF_DEPTH) + 1;
    localparam int unsigned SUM_W = OCC_W + 1;

    rd_state_e        state_q, state_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [CNT_W-1:0] words_q, words_d;
    logic             outst_q, outst_d;
    logic             from_drain_q, from_drain_d;
    logic             drain_done_q, drain_done_d;
    logic             err_rd_q, err_rd_d;
    logic             err_ack_q, err_ack_d;
    logic             rd_en_prev_q;

    logic [OCC_W-1:0] occ;
    logic             push;
    logic             resp;
    logic             read_state;
    logic             credit_ok;
    logic             throttled;

    // Words already buffered plus the one in flight must leave room for one more.
    assign read_state = (state_q == STREAM) || (state_q == DRAIN);
    assign credit_ok  = (SUM_W'(occ) + SUM_W'(outst_q)) < SUM_W'(BUF_DEPTH);
    assign throttled  = almost_empty && rd_en_prev_q;
    assign rd_en      = read_state && !empty && credit_ok && !throttled;

    assign resp = rd_ack || rd_err;
    assign push = rd_ack && outst_q;

    afifo_rd_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .BUF_DEPTH  (BUF_DEPTH)
    ) u_buf (
        .rd_clk      (rd_clk),
        .clear_n     (clear_n),
        .push_i      (push),
        .push_data_i (dout),
        .pop_i       (m_ready),
        .head_o      (m_data),
        .occ_o       (occ)
    );

    // State and bookkeeping registers.
    always_ff @(posedge rd_clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q      <= IDLE;
            remaining_q  <= '0;
            words_q      <= '0;
            outst_q      <= 1'b0;
            from_drain_q <= 1'b0;
            drain_done_q <= 1'b0;
            err_rd_q     <= 1'b0;
            err_ack_q    <= 1'b0;
            rd_en_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            words_q      <= words_d;
            outst_q      <= outst_d;
            from_drain_q <= from_drain_d;
            drain_done_q <= drain_done_d;
            err_rd_q     <= err_rd_d;
            err_ack_q    <= err_ack_d;
            rd_en_prev_q <= rd_en;
        end
    end

    // Next-state, response tracking and drain accounting.
    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        words_d      = words_q;
        outst_d      = outst_q;
        from_drain_d = from_drain_q;
        drain_done_d = 1'b0;
        err_rd_d     = err_rd_q;
        err_ack_d    = err_ack_q;

        // A new read in the same cycle as the previous response keeps one in flight.
        if (resp) begin
            outst_d = 1'b0;
        end
        if (rd_en) begin
            outst_d = 1'b1;
        end
        if (push) begin
            words_d = words_q + CNT_W'(1);
        end
        if (rd_err) begin
            err_rd_d = 1'b1;
        end
        if (resp && !outst_q) begin
            err_ack_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (drain_start) begin
                    if (drain_len != '0) begin
                        state_d     = DRAIN;
                        remaining_d = drain_len;
                    end else begin
                        drain_done_d = 1'b1;
                    end
                end else if (enable) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (!enable) begin
                    state_d      = FLUSH;
                    from_drain_d = 1'b0;
                end
            end
            DRAIN: begin
                if (rd_en) begin
                    remaining_d = remaining_q - CNT_W'(1);
                    if (remaining_q == CNT_W'(1)) begin
                        state_d      = FLUSH;
                        from_drain_d = 1'b1;
                    end
                end
            end
            FLUSH: begin
                // A drain is only complete once its words have left the buffer.
                if (!outst_q && (!from_drain_q || (occ == '0))) begin
                    state_d      = IDLE;
                    drain_done_d = from_drain_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign m_valid    = (occ != '0);
    assign drain_busy = (state_q == DRAIN) || ((state_q == FLUSH) && from_drain_q);
    assign drain_done = drain_done_q;
    assign words_rd   = words_q;
    assign err_rd     = err_rd_q;
    assign err_ack    = err_ack_q;

endmodule

// File: tb/tb_afifo_rd_ctrl.sv
// Directed bench for afifo_rd_ctrl with a small behavioural FIFO responder.
module tb_afifo_rd_ctrl;
    import afifo_pkg::*;

    logic        rd_clk = 1'b0;
    logic        clear_n;
    logic        enable;
    logic        drain_start;
    logic [15:0] drain_len;
    logic        rd_en;
    logic        empty;
    logic        almost_empty;
    logic        rd_ack;
    logic        rd_err;
    logic [7:0]  dout;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready;
    logic        drain_busy;
    logic        drain_done;
    logic [15:0] words_rd;
    logic        err_rd;
    logic        err_ack;

    afifo_rd_ctrl dut (
        .rd_clk       (rd_clk),
        .clear_n      (clear_n),
        .enable       (enable),
        .drain_start  (drain_start),
        .drain_len    (drain_len),
        .rd_en        (rd_en),
        .empty        (empty),
        .almost_empty (almost_empty),
        .rd_ack       (rd_ack),
        .rd_err       (rd_err),
        .dout         (dout),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .drain_busy   (drain_busy),
        .drain_done   (drain_done),
        .words_rd     (words_rd),
        .err_rd       (err_rd),
        .err_ack      (err_ack)
    );

    always #5 rd_clk = ~rd_clk;

    int n_run  = 0;
    int n_fail = 0;

    logic [7:0] fifo_q[$];
    logic [7:0] got[$];
    int   n_rden, n_done, n_bad_thr, n_bad_empty;
    logic prev_fire;
    logic ae_force, inj_err, inj_ack;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic update_flags();
        empty        = (fifo_q.size() == 0);
        almost_empty = ae_force || (fifo_q.size() <= 1);
    endtask

    task automatic load(input logic [7:0] w);
        fifo_q.push_back(w);
        update_flags();
    endtask

    // One clock: observe mid-cycle, then model the FIFO response after the edge.
    task automatic tick();
        logic fire;
        @(negedge rd_clk);
        fire = rd_en;
        if (fire) n_rden++;
        if (fire && empty) n_bad_empty++;
        if (fire && prev_fire && almost_empty) n_bad_thr++;
        prev_fire = fire;
        if (m_valid && m_ready) got.push_back(m_data);
        if (drain_done) n_done++;
        @(posedge rd_clk);
        #1;
        rd_ack      = 1'b0;
        rd_err      = 1'b0;
        drain_start = 1'b0;
        if (fire) begin
            if (inj_err || fifo_q.size() == 0) begin
                rd_err  = 1'b1;
                inj_err = 1'b0;
            end else begin
                rd_ack = 1'b1;
                dout   = fifo_q.pop_front();
            end
        end else if (inj_ack) begin
            rd_ack  = 1'b1;
            dout    = 8'hEE;
            inj_ack = 1'b0;
        end
        update_flags();
    endtask

    task automatic do_reset();
        clear_n     = 1'b0;
        enable      = 1'b0;
        drain_start = 1'b0;
        drain_len   = '0;
        m_ready     = 1'b0;
        rd_ack      = 1'b0;
        rd_err      = 1'b0;
        dout        = '0;
        ae_force    = 1'b0;
        inj_err     = 1'b0;
        inj_ack     = 1'b0;
        fifo_q.delete();
        update_flags();
        repeat (2) tick();
        got.delete();
        n_rden = 0; n_done = 0; n_bad_thr = 0; n_bad_empty = 0; prev_fire = 1'b0;
        clear_n = 1'b1;
    endtask

    initial begin
        logic [7:0] exp_w;
        int         done_before;

        // Reset state
        do_reset();
        check("rst_rd_en",      32'(rd_en),      32'd0);
        check("rst_m_valid",    32'(m_valid),    32'd0);
        check("rst_m_data",     32'(m_data),     32'd0);
        check("rst_words_rd",   32'(words_rd),   32'd0);
        check("rst_err_rd",     32'(err_rd),     32'd0);
        check("rst_err_ack",    32'(err_ack),    32'd0);
        check("rst_drain_busy", 32'(drain_busy), 32'd0);
        check("rst_drain_done", 32'(drain_done), 32'd0);
        check("rst_state",      32'(dut.state_q), 32'(IDLE));

        // Drain 5 words
        for (int i = 0; i < 5; i++) load(8'h11 + 8'(i));
        m_ready = 1'b1; drain_len = 16'd5; drain_start = 1'b1;
        tick();
        check("drain_busy_on",  32'(drain_busy), 32'd1);
        check("drain_rd_en_n",  32'(rd_en),      32'd1);
        check("drain_mv_n",     32'(m_valid),    32'd0);
        tick();
        check("drain_mv_n1",    32'(m_valid),    32'd0);
        tick();
        check("drain_mv_n2",    32'(m_valid),    32'd1);
        check("drain_md_n2",    32'(m_data),     32'h11);
        for (int i = 0; i < 60 && n_done == 0; i++) tick();
        check("drain_rd_cnt",   32'(n_rden),     32'd5);
        check("drain_words_rd", 32'(words_rd),   32'd5);
        check("drain_got_cnt",  32'(got.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            exp_w = 8'h11 + 8'(i);
            check("drain_word", 32'(got[i]), 32'(exp_w));
        end
        check("drain_busy_off", 32'(drain_busy), 32'd0);
        repeat (3) tick();
        check("drain_done_cnt", 32'(n_done),     32'd1);
        check("drain_done_low", 32'(drain_done), 32'd0);

        // Backpressure in stream mode
        do_reset();
        for (int i = 0; i < 10; i++) load(8'h20 + 8'(i));
        enable = 1'b1;
        repeat (15) tick();
        check("bp_rd_cnt",  32'(n_rden),         32'd4);
        check("bp_occ",     32'(dut.u_buf.occ_o), 32'd4);
        check("bp_m_valid", 32'(m_valid),        32'd1);
        check("bp_head",    32'(m_data),         32'h20);
        check("bp_err_rd",  32'(err_rd),         32'd0);
        check("bp_err_ack", 32'(err_ack),        32'd0);
        m_ready = 1'b1;
        for (int i = 0; i < 80 && got.size() < 10; i++) tick();
        check("bp_got_cnt", 32'(got.size()), 32'd10);
        for (int i = 0; i < 10; i++) begin
            exp_w = 8'h20 + 8'(i);
            check("bp_word", 32'(got[i]), 32'(exp_w));
        end
        check("bp_words_rd", 32'(words_rd), 32'd10);
        enable = 1'b0;
        repeat (4) tick();
        check("bp_state_idle", 32'(dut.state_q), 32'(IDLE));

        // Empty / almost-empty throttle
        do_reset();
        ae_force = 1'b1;
        load(8'h31); load(8'h32);
        m_ready = 1'b1; enable = 1'b1;
        repeat (20) tick();
        check("thr_back_to_back", 32'(n_bad_thr),   32'd0);
        check("thr_rd_on_empty",  32'(n_bad_empty), 32'd0);
        check("thr_rd_cnt",       32'(n_rden),      32'd2);
        check("thr_got_cnt",      32'(got.size()),  32'd2);
        check("thr_word0",        32'(got[0]),      32'h31);
        check("thr_word1",        32'(got[1]),      32'h32);
        check("thr_err_rd",       32'(err_rd),      32'd0);

        // Error injection: rd_err for a read, then a spurious rd_ack
        do_reset();
        load(8'h41);
        m_ready = 1'b1; enable = 1'b1; inj_err = 1'b1;
        tick();
        for (int i = 0; i < 30 && words_rd == 16'd0; i++) tick();
        enable = 1'b0;
        repeat (5) tick();
        check("err_rd_set",    32'(err_rd),  32'd1);
        check("err_ack_clear", 32'(err_ack), 32'd0);
        inj_ack = 1'b1;
        repeat (3) tick();
        check("err_ack_set",      32'(err_ack),    32'd1);
        check("err_words_rd",     32'(words_rd),   32'd1);
        check("err_got_cnt",      32'(got.size()), 32'd1);
        check("err_got_word",     32'(got[0]),     32'h41);
        check("err_no_spurious",  32'(m_valid),    32'd0);
        repeat (5) tick();
        check("err_rd_sticky",  32'(err_rd),  32'd1);
        check("err_ack_sticky", 32'(err_ack), 32'd1);

        // Reset in the middle of a drain
        do_reset();
        for (int i = 0; i < 10; i++) load(8'h50 + 8'(i));
        m_ready = 1'b1; drain_len = 16'd8; drain_start = 1'b1;
        tick();
        for (int i = 0; i < 30 && n_rden < 3; i++) tick();
        check("mid_reads_before", 32'(n_rden), 32'd3);
        clear_n = 1'b0;
        rd_ack  = 1'b0;
        rd_err  = 1'b0;
        #1;
        check("mid_rd_en",      32'(rd_en),       32'd0);
        check("mid_m_valid",    32'(m_valid),     32'd0);
        check("mid_words_rd",   32'(words_rd),    32'd0);
        check("mid_drain_busy", 32'(drain_busy),  32'd0);
        check("mid_state",      32'(dut.state_q), 32'(IDLE));
        done_before = n_done;
        repeat (2) tick();
        clear_n = 1'b1;
        repeat (10) tick();
        check("mid_no_done",    32'(n_done - done_before), 32'd0);
        check("mid_state_post", 32'(dut.state_q),         32'(IDLE));
        check("mid_err_ack",    32'(err_ack),             32'd0);
        check("mid_words_post", 32'(words_rd),            32'd0);

        // Simultaneous drain_start and enable
        do_reset();
        load(8'h61); load(8'h62);
        m_ready = 1'b1; enable = 1'b1; drain_len = 16'd2; drain_start = 1'b1;
        tick();
        check("sim_state_drain", 32'(dut.state_q), 32'(DRAIN));
        check("sim_busy",        32'(drain_busy),  32'd1);
        for (int i = 0; i < 40 && n_done == 0; i++) tick();
        check("sim_done_cnt",     32'(n_done),      32'd1);
        check("sim_rd_cnt",       32'(n_rden),      32'd2);
        check("sim_state_stream", 32'(dut.state_q), 32'(STREAM));
        check("sim_busy_off",     32'(drain_busy),  32'd0);
        load(8'h63);
        repeat (6) tick();
        check("sim_got_cnt",  32'(got.size()), 32'd3);
        check("sim_word0",    32'(got[0]),     32'h61);
        check("sim_word1",    32'(got[1]),     32'h62);
        check("sim_word2",    32'(got[2]),     32'h63);
        check("sim_words_rd", 32'(words_rd),   32'd3);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
